aes_inv_cipher_iter: RTL and testbench
======================================

# aes_inv_cipher_iter

Iterative AES inverse cipher that decrypts one 128-bit block by applying one inverse round per clock. It generalises the single inverse-round datapath to a complete decryption sequence with parameter-selected round count (AES-128/192/256) and valid/ready handshakes on both sides. It sits between the block-input buffer and the plaintext output stage. Round keys come from an external key-schedule store, addressed by this block.

## Interface
Parameters:
- NR, 10, number of rounds; legal values 10, 12, 14. Any other value is a synthesis-time error.
- IDX_W, 4, round-key index width (localparam, not overridable).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  block can be accepted; high only in IDLE.
- in_data  in  128  ciphertext block, byte 0 in [127:120].
- rk_idx  out  IDX_W  round-key index requested this cycle.
- rk_data  in  128  round key for rk_idx; combinational, same cycle.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts plaintext.
- out_data  out  128  plaintext block.
- busy  out  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN, DONE. A 128-bit state register and a round counter rnd[IDX_W-1:0] hold the working data.
- IDLE:
  - in_ready=1 and rk_idx=NR.
  - When in_valid && in_ready: state <= in_data ^ rk_data, rnd <= NR-1, go to RUN.
- RUN:
  - rk_idx=rnd.
  - state <= AddRoundKey(InvMixColumns(InvSubBytes(InvShiftRows(state))), rk_data) when rnd != 0.
  - When rnd == 0, InvMixColumns is skipped (final round).
  - When rnd==0, go to DONE. Otherwise rnd <= rnd-1.
- DONE:
  - out_valid=1 and out_data=state. Both are held stable until out_ready.
  - When out_ready: go to IDLE.
- in_ready is low in RUN and DONE. There is no overlap of blocks. in_valid is ignored outside IDLE.
- The inverse S-box uses the codebase's existing inverse S-box module, with 16 instances. InvShiftRows, InvMixColumns and AddRoundKey follow FIPS-197 byte ordering.
- Reset:
  - Forces IDLE, state=0, rnd=0. It aborts any block in progress with no output produced.
  - After the reset edge: in_ready=1, out_valid=0, busy=0, out_data=0, rk_idx=NR.
- out_ready while not in DONE has no effect.
- in_valid and out_ready both high in DONE: only the output handoff occurs. The input is accepted on a later cycle in IDLE.

## Timing
- Acceptance edge is E0. The RUN edges are E1..ENR. out_valid is high in the cycle after ENR.
- Latency from acceptance to out_valid is NR cycles: 10, 12 or 14.
- With out_ready held high, one block completes every NR+2 cycles: one IDLE cycle plus NR RUN cycles plus one DONE cycle.
- rk_idx is registered-state-derived (from FSM/rnd only). rk_data must settle within the same cycle. There is no combinational path from rk_data to rk_idx.
- The critical path is the full inverse round plus the key XOR. A single cycle per round is required.

## Configuration
- AES_INV_ZEROIZE_EN defined:
  - The state register is cleared to 0 on the out_ready handoff edge.
  - out_data is forced to 0 whenever out_valid=0, so no intermediate round data is ever visible on out_data.
- Undefined:
  - out_data = state at all times, so intermediate rounds are visible.
  - The state register keeps the last plaintext after handoff.

## Test plan
- AES-128 decrypt (NR=10)
  - Stimulus: in_data=69c4e0d86a7b0430d8cdb78070b4c55a; bench supplies the expanded key of 000102…0f on rk_idx.
  - Required response: out_valid exactly 10 cycles after acceptance, out_data=00112233445566778899aabbccddeeff.
- AES-192 and AES-256
  - NR=12: in_data dda97ca4864cdfe06eaf70a0ec0d7191 with key 000102…17 → 00112233…ff after 12 cycles.
  - NR=14: in_data 8ea2b7ca516745bfeafc49904b496089 with key 000102…1f → 00112233…ff after 14 cycles.
- Output backpressure
  - Stimulus: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 throughout.
  - Required response: out_data stable and in_ready=0 during the stall. A new block is accepted only after handoff, one cycle later in IDLE.
- Reset mid-operation
  - Stimulus: assert rst at RUN with rnd=5.
  - Required response: next cycle in_ready=1, busy=0, out_valid=0, out_data=0. The aborted block never appears. A following block decrypts correctly.
- rk_idx sequence
  - Required response: after acceptance, rk_idx reads NR, NR-1, …, 0 on consecutive cycles, then NR in IDLE.
- Zeroize
  - With AES_INV_ZEROIZE_EN: out_data=0 during RUN and after handoff.
  - Without it: out_data shows intermediate round values during RUN, and out_data=00112233…ff persists in IDLE after handoff.

Source files
------------

// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_cipher_iter (with helper aes_inv_sbox)
//  Description : Iterative AES-128/192/256 inverse cipher, one inverse round
//                per clock, valid/ready on both sides, external round keys.
//                Optional macro AES_INV_ZEROIZE_EN hides non-final state.
//  Revision    : 1.0 - initial release
// ============================================================================

module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [2047:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry k sits at bit offset 8*(255-k); 255-k is ~k for an 8-bit k.
    assign o_byte = c_inv_sbox[{~i_byte, 3'b000} +: 8];
endmodule

module aes_inv_cipher_iter #(
    parameter  int NR    = 10,
    localparam int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic [IDX_W-1:0] rk_idx,
    input  logic [127:0]     rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy
);
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_illegal
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end

    localparam logic [IDX_W-1:0] c_nr_idx    = IDX_W'(NR);
    localparam logic [IDX_W-1:0] c_rnd_start = IDX_W'(NR - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_fsm;
    state_t           w_fsm_nxt;
    logic [127:0]     r_state;
    logic [127:0]     w_state_nxt;
    logic [IDX_W-1:0] r_rnd;
    logic [IDX_W-1:0] w_rnd_nxt;

    logic [127:0]     w_isr;
    logic [127:0]     w_sub;
    logic [127:0]     w_imc;
    logic [127:0]     w_round;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] imc_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31-8*i -: 8];
            x2     = xtime(a[i]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    // Byte k is row k%4 of column k/4; row r rotates right by r columns.
    for (genvar k = 0; k < 16; k++) begin : g_byte
        localparam int c_src = 4 * (((k / 4) - (k % 4) + 4) % 4) + (k % 4);
        assign w_isr[127-8*k -: 8] = r_state[127-8*c_src -: 8];
        aes_inv_sbox u_sbox (
            .i_byte (w_isr[127-8*k -: 8]),
            .o_byte (w_sub[127-8*k -: 8])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign w_imc[127-32*c -: 32] = imc_col(w_sub[127-32*c -: 32]);
    end

    assign w_round = (r_rnd == '0) ? w_sub : w_imc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_rnd   <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        rk_idx      = c_nr_idx;
        case (r_fsm)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = in_data ^ rk_data;
                    w_rnd_nxt   = c_rnd_start;
                    w_fsm_nxt   = S_RUN;
                end
            end
            S_RUN: begin
                rk_idx      = r_rnd;
                w_state_nxt = w_round ^ rk_data;
                if (r_rnd == '0) begin
                    w_fsm_nxt = S_DONE;
                end else begin
                    w_rnd_nxt = r_rnd - IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_fsm_nxt = S_IDLE;
`ifdef AES_INV_ZEROIZE_EN
                    w_state_nxt = '0;
`endif
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    assign busy      = (r_fsm != S_IDLE);

`ifdef AES_INV_ZEROIZE_EN
    assign out_data = (r_fsm == S_DONE) ? r_state : '0;
`else
    assign out_data = r_state;
`endif
endmodule

`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_cipher_iter
//  Description : Directed bench for aes_inv_cipher_iter with NR = 10/12/14
//                using FIPS-197 vectors; honours AES_INV_ZEROIZE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_iter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   in_valid  = '0;
    logic [2:0]   in_ready;
    logic [127:0] in_data [3];
    logic [3:0]   rk_idx [3];
    logic [127:0] rk_data [3];
    logic [2:0]   out_valid;
    logic [2:0]   out_ready = '0;
    logic [127:0] out_data [3];
    logic [2:0]   busy;

    logic [127:0] rks [0:2][0:14];
    int           n_checks = 0;
    int           n_fail   = 0;

    localparam logic [255:0] c_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_ct12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] c_ct14 = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.NR(10)) u_dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .rk_idx(rk_idx[0]), .rk_data(rk_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0]));
    aes_inv_cipher_iter #(.NR(12)) u_dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .rk_idx(rk_idx[1]), .rk_data(rk_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1]));
    aes_inv_cipher_iter #(.NR(14)) u_dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .rk_idx(rk_idx[2]), .rk_data(rk_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2]));

    assign rk_data[0] = rks[0][rk_idx[0]];
    assign rk_data[1] = rks[1][rk_idx[1]];
    assign rk_data[2] = rks[2][rk_idx[2]];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from its definition: GF(2^8) inverse then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
            r[119-32*c -: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
            r[111-32*c -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
            r[103-32*c -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
        return r;
    endfunction

    // Equivalent-inverse-cipher schedule: middle round keys pass through InvMixColumns.
    task automatic expand(input int sel, input int nk, input int nr);
        logic [31:0]  w [0:59];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [127:0] rk;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = c_key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            rks[sel][r] = (r > 0 && r < nr) ? inv_mix(rk) : rk;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_to_done(input int d, input int nr, input logic [127:0] ct);
        in_data[d]  = ct;
        in_valid[d] = 1'b1;
        chk("idle_in_ready", 128'(in_ready[d]), 128'd1);
        chk("idle_rk_idx", 128'(rk_idx[d]), 128'(nr));
        tick();
        in_valid[d] = 1'b0;
`ifdef AES_INV_ZEROIZE_EN
        chk("run_out_data_zeroized", out_data[d], 128'd0);
`else
        chk("run_out_data_first_round", out_data[d], ct ^ rks[d][nr]);
`endif
        chk("run_busy", 128'(busy[d]), 128'd1);
        chk("run_in_ready", 128'(in_ready[d]), 128'd0);
        for (int k = nr - 1; k >= 0; k--) begin
            chk("run_rk_idx", 128'(rk_idx[d]), 128'(k));
            chk("run_out_valid_low", 128'(out_valid[d]), 128'd0);
            tick();
        end
        chk("done_out_valid", 128'(out_valid[d]), 128'd1);
        chk("done_plaintext", out_data[d], c_pt);
    endtask

    task automatic handoff(input int d, input int nr);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        chk("post_in_ready", 128'(in_ready[d]), 128'd1);
        chk("post_out_valid", 128'(out_valid[d]), 128'd0);
        chk("post_busy", 128'(busy[d]), 128'd0);
        chk("post_rk_idx", 128'(rk_idx[d]), 128'(nr));
`ifdef AES_INV_ZEROIZE_EN
        chk("post_out_data_zeroized", out_data[d], 128'd0);
`else
        chk("post_out_data_kept", out_data[d], c_pt);
`endif
    endtask

    initial begin
        for (int d = 0; d < 3; d++) in_data[d] = '0;
        expand(0, 4, 10);
        expand(1, 6, 12);
        expand(2, 8, 14);

        // Reset state
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready", 128'(in_ready[d]), 128'd1);
            chk("rst_out_valid", 128'(out_valid[d]), 128'd0);
            chk("rst_busy", 128'(busy[d]), 128'd0);
            chk("rst_out_data", out_data[d], 128'd0);
            chk("rst_rk_idx", 128'(rk_idx[d]), 128'(10 + 2 * d));
        end
        rst = 1'b0;
        tick();

        // AES-128 then a 5-cycle stall with a new block pending
        run_to_done(0, 10, c_ct10);
        in_data[0]  = c_ct10;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_out_valid", 128'(out_valid[0]), 128'd1);
            chk("stall_out_data", out_data[0], c_pt);
            chk("stall_in_ready", 128'(in_ready[0]), 128'd0);
        end
        handoff(0, 10);
        tick();
        in_valid[0] = 1'b0;
        chk("accept_after_handoff_busy", 128'(busy[0]), 128'd1);
        chk("accept_after_handoff_rk_idx", 128'(rk_idx[0]), 128'd9);

        // Abort in RUN at rnd = 5
        for (int i = 0; i < 4; i++) tick();
        chk("abort_point_rk_idx", 128'(rk_idx[0]), 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 128'(in_ready[0]), 128'd1);
        chk("abort_busy", 128'(busy[0]), 128'd0);
        chk("abort_out_valid", 128'(out_valid[0]), 128'd0);
        chk("abort_out_data", out_data[0], 128'd0);
        chk("abort_rk_idx", 128'(rk_idx[0]), 128'd10);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_no_output", 128'(out_valid[0]), 128'd0);
        end

        // Fresh blocks for each key size
        run_to_done(0, 10, c_ct10);
        handoff(0, 10);
        run_to_done(1, 12, c_ct12);
        handoff(1, 12);
        run_to_done(2, 14, c_ct14);
        handoff(2, 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
